uart_rx_fifo: RTL and testbench

Receive-side buffer placed directly downstream of the UART receiver in `uart_top`. It captures each byte flagged by `rx_ready`/`rx_data_out` and acknowledges it on `rdy_clr`. Bytes are stored in a first-word-fall-through FIFO that the host drains at its own pace. Overrun is recorded when a byte arrives while the FIFO is full.

---
 rtl/uart_rx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver, with rx_ready/rdy_clr handshake,
// sticky overrun flag and optional almost-full watermark (macro UART_RX_FIFO_WATERMARK_EN).
module uart_rx_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_ready,
    input  logic [7:0]               rx_data,
    output logic                     rdy_clr,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     ovr_clr,
    output logic                     almost_full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_LEVEL > DEPTH) begin : g_param_check
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and AF_LEVEL <= DEPTH");
    end

    typedef enum logic [0:0] {
        StIdle,
        StAck
    } state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        mem [DEPTH];

    logic wr_try;
    logic wr_accept;
    logic wr_drop;
    logic do_read;

    // Capture FSM: exactly one write attempt per rx_ready assertion.
    always_comb begin
        state_d = state_q;
        wr_try  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_ready) begin
                    wr_try  = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                if (!rx_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign count   = count_q;
    assign overrun = overrun_q;
    assign rdy_clr = (state_q == StAck);

    // A full FIFO still takes the byte when the host frees a slot in the same cycle.
    assign do_read   = rd_en && !empty;
    assign wr_accept = wr_try && (!full || do_read);
    assign wr_drop   = wr_try && !wr_accept;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({wr_accept, do_read})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (wr_drop) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (reset && wr_accept) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

    // Gating with empty keeps rd_data at 0 after reset without clearing the array.
    assign rd_data = empty ? 8'h00 : mem[rd_ptr_q];

`ifdef UART_RX_FIFO_WATERMARK_EN
    assign almost_full = (count_q >= CntW'(AF_LEVEL));
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AF_LEVEL = 12;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_ready;
    logic [7:0]    rx_data;
    logic          rdy_clr;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overrun;
    logic          ovr_clr;
    logic          almost_full;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rdy_clr     (rdy_clr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr),
        .almost_full (almost_full)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: stored bytes, sticky overrun, and whether the current rx_ready
    // assertion has already been consumed (acknowledge outstanding).
    byte unsigned m_q[$];
    bit           m_ovr;
    bit           m_ack;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit try_wr;
        bit rd_ok;
        bit acc;
        if (!reset) begin
            m_q.delete();
            m_ovr = 1'b0;
            m_ack = 1'b0;
        end else begin
            try_wr = rx_ready && !m_ack;
            rd_ok  = rd_en && (m_q.size() > 0);
            acc    = try_wr && ((m_q.size() < DEPTH) || rd_ok);
            if (rd_ok) void'(m_q.pop_front());
            if (acc) m_q.push_back(rx_data);
            if (try_wr && !acc) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
            m_ack = rx_ready;
        end
    endtask

    task automatic check_all();
        bit exp_af;
`ifdef UART_RX_FIFO_WATERMARK_EN
        exp_af = (m_q.size() >= AF_LEVEL);
`else
        exp_af = 1'b0;
`endif
        check_val("rdy_clr", 32'(rdy_clr), 32'(m_ack));
        check_val("count", 32'(count), 32'(m_q.size()));
        check_val("empty", 32'(empty), 32'(m_q.size() == 0));
        check_val("full", 32'(full), 32'(m_q.size() == DEPTH));
        check_val("overrun", 32'(overrun), 32'(m_ovr));
        check_val("almost_full", 32'(almost_full), 32'(exp_af));
        if (m_q.size() > 0) check_val("rd_data", 32'(rd_data), 32'(m_q[0]));
    endtask

    // One clock edge with the currently driven inputs; outputs checked 1ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send(input byte unsigned b, input int hold, input bit rd_same);
        rx_ready = 1'b1;
        rx_data  = b;
        rd_en    = rd_same;
        tick();
        check_val("rdy_clr_rise", 32'(rdy_clr), 32'd1);
        rd_en = 1'b0;
        repeat (hold) tick();
        rx_ready = 1'b0;
        tick();
        check_val("rdy_clr_fall", 32'(rdy_clr), 32'd0);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (m_q.size() > 0 && guard < 64) begin
            pop();
            guard++;
        end
        check_val("drained", 32'(empty), 32'd1);
    endtask

    initial begin
        reset    = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        ovr_clr  = 1'b0;
        m_ovr    = 1'b0;
        m_ack    = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check_val("reset_rd_data", 32'(rd_data), 32'h0);
        check_val("reset_empty", 32'(empty), 32'd1);
        reset = 1'b1;
        tick();

        // Single byte
        send(8'hA5, 0, 1'b0);
        check_val("single_count", 32'(count), 32'd1);
        check_val("single_data", 32'(rd_data), 32'hA5);
        pop();
        check_val("single_empty", 32'(empty), 32'd1);

        // Slow receiver clear: one write only
        send(8'h5A, 5, 1'b0);
        check_val("slow_count", 32'(count), 32'd1);
        drain();

        // Fill, overrun, ordered drain, clear
        for (int i = 0; i < 16; i++) send(8'(i), 0, 1'b0);
        check_val("fill_full", 32'(full), 32'd1);
        send(8'hFF, 0, 1'b0);
        check_val("ovr_set", 32'(overrun), 32'd1);
        check_val("ovr_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_val("ordered", 32'(rd_data), 32'(i));
            pop();
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check_val("ovr_clr", 32'(overrun), 32'd0);

        // Full with simultaneous read: write accepted
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 0, 1'b0);
        send(8'h99, 0, 1'b1);
        check_val("full_rw_count", 32'(count), 32'd16);
        check_val("full_rw_ovr", 32'(overrun), 32'd0);
        check_val("full_rw_head", 32'(rd_data), 32'h41);
        drain();

        // Wrap and watermark
        for (int i = 0; i < 12; i++) send(8'(8'h20 + i), 0, 1'b0);
`ifdef UART_RX_FIFO_WATERMARK_EN
        check_val("af_rise", 32'(almost_full), 32'd1);
        pop();
        check_val("af_fall", 32'(almost_full), 32'd0);
`endif
        drain();
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i), 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_val("wrap_data", 32'(rd_data), 32'(8'h30 + i));
            pop();
        end

        // Reset mid-ACK
        for (int i = 0; i < 3; i++) send(8'(8'h70 + i), 0, 1'b0);
        rx_ready = 1'b1;
        rx_data  = 8'hC3;
        tick();
        check_val("midack_count", 32'(count), 32'd4);
        reset = 1'b0;
        tick();
        check_val("rst_rdy_clr", 32'(rdy_clr), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b1;
        tick();
        check_val("pending_recapture", 32'(count), 32'd1);
        check_val("pending_data", 32'(rd_data), 32'hC3);
        rx_ready = 1'b0;
        tick();
        drain();

        // Randomized traffic; read rate varies by phase to visit full and empty often
        for (int c = 0; c < 4000; c++) begin
            int rd_pct;
            rd_pct = ((c / 500) % 2 == 0) ? 15 : 60;
            if (!rx_ready) begin
                if ($urandom_range(99) < 40) begin
                    rx_ready = 1'b1;
                    rx_data  = 8'($urandom);
                end
            end else if (m_ack && $urandom_range(99) < 50) begin
                rx_ready = 1'b0;
            end
            rd_en   = ($urandom_range(99) < rd_pct);
            ovr_clr = ($urandom_range(99) < 5);
            reset   = ($urandom_range(999) < 2) ? 1'b0 : 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
